// File: rtl/line_pkg.sv
// line_pkg: shared state encoding, default coordinate widths and arithmetic width helper.
package line_pkg;
  localparam int XW_DEF = 11;
  localparam int YW_DEF = 10;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int arith_w(input int xw, input int yw);
    return (xw > yw ? xw : yw) + 2;
  endfunction
endpackage

// File: rtl/line_raster_if.sv
// line_raster_if: line request plus pixel stream handshake bundle.
interface line_raster_if import line_pkg::*; #(parameter int XW = XW_DEF, parameter int YW = YW_DEF);
  logic start;
  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic busy, px_valid, px_ready, px_last, done;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  modport master (output start, x0, x1, y0, y1, px_ready,
                  input busy, px_valid, px_x, px_y, px_last, done);
  modport slave (input start, x0, x1, y0, y1, px_ready,
                 output busy, px_valid, px_x, px_y, px_last, done);
endinterface

// File: rtl/line_step.sv
// line_step: one combinational Bresenham step; both tests use the pre-update doubled error.
module line_step #(parameter int XW = 11, parameter int YW = 10, parameter int W = 13) (
  input  logic [XW-1:0]        x,
  input  logic [YW-1:0]        y,
  input  logic signed [W-1:0]  err,
  input  logic signed [W-1:0]  dx,
  input  logic signed [W-1:0]  dy,
  input  logic signed [1:0]    sx,
  input  logic signed [1:0]    sy,
  output logic [XW-1:0]        nx,
  output logic [YW-1:0]        ny,
  output logic signed [W-1:0]  nerr
);
  logic signed [W-1:0] e2;
  logic stx, sty;
  always_comb begin
    e2 = err <<< 1;
    stx = e2 > dy;
    sty = e2 < dx;
    nerr = err + (stx ? dy : '0) + (sty ? dx : '0);
    nx = stx ? x + XW'(sx) : x;
    ny = sty ? y + YW'(sy) : y;
  end
endmodule

// File: rtl/line_raster.sv
// line_raster: Bresenham line generator streaming one pixel per accepted handshake.
module line_raster import line_pkg::*; #(parameter int XW = XW_DEF, parameter int YW = YW_DEF) (
  input logic clk,
  input logic reset,
  line_raster_if.slave bus
);
  localparam int W = arith_w(XW, YW);
  state_t state, state_n;
  logic [XW-1:0] x, ex, nx, adx;
  logic [YW-1:0] y, ey, ny, ady;
  logic signed [W-1:0] err, dx, dy, nerr, dx0, dy0;
  logic signed [1:0] sx, sy;
  logic last, hs, accept, done_r;
  assign last = state == RUN && x == ex && y == ey;
  assign hs = state == RUN && bus.px_ready;
  assign accept = state == IDLE && bus.start;
  assign adx = bus.x1 >= bus.x0 ? bus.x1 - bus.x0 : bus.x0 - bus.x1;
  assign ady = bus.y1 >= bus.y0 ? bus.y1 - bus.y0 : bus.y0 - bus.y1;
  assign dx0 = W'(adx);
  assign dy0 = -(W'(ady));
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb state_n = accept ? RUN : (hs && last) ? IDLE : state;
  always_comb begin
    bus.busy = state == RUN;
    bus.px_valid = state == RUN;
    bus.px_last = last;
    bus.px_x = x;
    bus.px_y = y;
    bus.done = done_r;
  end
  line_step #(.XW(XW), .YW(YW), .W(W)) u_step (
    .x(x), .y(y), .err(err), .dx(dx), .dy(dy), .sx(sx), .sy(sy),
    .nx(nx), .ny(ny), .nerr(nerr)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      x <= '0;
      y <= '0;
      ex <= '0;
      ey <= '0;
      err <= '0;
      dx <= '0;
      dy <= '0;
      sx <= '0;
      sy <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= hs && last;
      if (accept) begin
        x <= bus.x0;
        y <= bus.y0;
        ex <= bus.x1;
        ey <= bus.y1;
        dx <= dx0;
        dy <= dy0;
        err <= dx0 + dy0;
        sx <= bus.x1 >= bus.x0 ? 2'sb01 : 2'sb11;
        sy <= bus.y1 >= bus.y0 ? 2'sb01 : 2'sb11;
      end else if (hs && !last) begin
        x <= nx;
        y <= ny;
        err <= nerr;
      end
    end
endmodule

// File: tb/tb_line_raster.sv
// tb_line_raster: directed checks of the line rasteriser against hand-derived pixel lists.
module tb_line_raster;
  logic clk = 0;
  logic reset;
  int errors = 0;
  int checks = 0;
  int qx[$], qy[$], ql[$];
  int ex[$], ey[$];
  int bc;
  line_raster_if #(.XW(11), .YW(10)) bus ();
  line_raster dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_line(input int x0, input int y0, input int x1, input int y1);
    bus.x0 = 11'(x0);
    bus.y0 = 10'(y0);
    bus.x1 = 11'(x1);
    bus.y1 = 10'(y1);
    bus.start = 1;
    @(posedge clk); #1;
    bus.start = 0;
  endtask

  task automatic collect(input bit rnd, input bit poke, output int busy_cyc);
    int cyc;
    bit r, hold;
    int hx, hy, hl;
    qx.delete(); qy.delete(); ql.delete();
    busy_cyc = 0;
    hold = 0;
    hx = 0; hy = 0; hl = 0;
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 20000) begin
      if (hold) begin
        chk("hold_x", int'(bus.px_x), hx);
        chk("hold_y", int'(bus.px_y), hy);
        chk("hold_last", int'(bus.px_last), hl);
      end
      if (bus.busy) busy_cyc++;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.px_ready = r;
      if (poke) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.x0 = 11'd5; bus.y0 = 10'd7; bus.x1 = 11'd100; bus.y1 = 10'd3;
      end
      if (bus.px_valid && r) begin
        qx.push_back(int'(bus.px_x));
        qy.push_back(int'(bus.px_y));
        ql.push_back(int'(bus.px_last));
      end
      hold = bus.px_valid && !r;
      hx = int'(bus.px_x); hy = int'(bus.px_y); hl = int'(bus.px_last);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 0;
    bus.px_ready = 0;
    chk("no_timeout", int'(cyc < 20000), 1);
    chk("busy_after_last", int'(bus.busy), 0);
    chk("valid_after_last", int'(bus.px_valid), 0);
    @(posedge clk); #1;
    chk("done_one_cycle", int'(bus.done), 0);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_count"}, qx.size(), ex.size());
    for (int i = 0; i < qx.size() && i < ex.size(); i++) begin
      chk({tag, "_x"}, qx[i], ex[i]);
      chk({tag, "_y"}, qy[i], ey[i]);
      chk({tag, "_last"}, ql[i], int'(i == ex.size() - 1));
    end
  endtask

  initial begin
    int bad_x, bad_y, bad_l;
    reset = 1;
    bus.start = 0; bus.px_ready = 0;
    bus.x0 = 0; bus.y0 = 0; bus.x1 = 0; bus.y1 = 0;
    @(posedge clk); #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_valid", int'(bus.px_valid), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_x", int'(bus.px_x), 0);
    reset = 0;
    @(posedge clk); #1;

    start_line(0, 0, 4, 0);
    chk("first_pixel_valid", int'(bus.px_valid), 1);
    collect(0, 0, bc);
    ex = '{0, 1, 2, 3, 4}; ey = '{0, 0, 0, 0, 0};
    check_seq("horiz");
    chk("horiz_busy_cycles", bc, 5);

    start_line(0, 0, 2, 5);
    collect(0, 0, bc);
    ex = '{0, 0, 1, 1, 2, 2}; ey = '{0, 1, 2, 3, 4, 5};
    check_seq("steep");

    start_line(10, 10, 7, 8);
    collect(1, 0, bc);
    ex = '{10, 9, 8, 7}; ey = '{10, 9, 9, 8};
    check_seq("neg");

    start_line(3, 3, 3, 3);
    chk("point_last", int'(bus.px_last), 1);
    collect(0, 0, bc);
    ex = '{3}; ey = '{3};
    check_seq("point");
    chk("point_busy_cycles", bc, 1);

    start_line(0, 0, 2047, 1023);
    collect(1, 1, bc);
    chk("long_count", qx.size(), 2048);
    bad_x = 0; bad_y = 0; bad_l = 0;
    for (int i = 0; i < qx.size(); i++) begin
      if (qx[i] != i) bad_x++;
      if (i == 0 ? qy[i] != 0 : (qy[i] - qy[i-1] < 0 || qy[i] - qy[i-1] > 1)) bad_y++;
      if (ql[i] != int'(i == qx.size() - 1)) bad_l++;
    end
    chk("long_x_seq", bad_x, 0);
    chk("long_y_seq", bad_y, 0);
    chk("long_last", bad_l, 0);
    chk("long_end_y", qy.size() > 0 ? qy[qy.size() - 1] : -1, 1023);

    start_line(0, 0, 9, 9);
    bus.px_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("third_pixel_x", int'(bus.px_x), 2);
    reset = 1;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_valid", int'(bus.px_valid), 0);
    chk("arst_last", int'(bus.px_last), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_x", int'(bus.px_x), 0);
    chk("arst_y", int'(bus.px_y), 0);
    bus.px_ready = 0;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    start_line(1, 1, 2, 2);
    collect(0, 0, bc);
    ex = '{1, 2}; ey = '{1, 2};
    check_seq("after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
